if_fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences inst_rom. It owns the PC and drives the ROM's ce and address each cycle. Fetched 64-bit instructions go into a small prefetch FIFO with a valid/ready handshake toward ID. It supports start, halt and branch redirect with flush, and sits between inst_rom and the IF/ID boundary.

---
 rtl/if_fetch_ctrl_pkg.sv | 25 ++
 rtl/if_fetch_ctrl_if.sv | 23 ++
 rtl/if_fetch_ctrl_fifo.sv | 50 +++++
 rtl/if_fetch_ctrl.sv | 77 +++++++
 tb/tb_if_fetch_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared widths, chip-enable levels and fetch FSM encodings for the IF stage.
package if_fetch_ctrl_pkg;

  localparam int unsigned InstAddrBus   = 32;
  localparam int unsigned InstBus       = 64;
  localparam int unsigned FetchStateBus = 2;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic [InstBus-1:0] ZeroDoubleWord = '0;

  typedef enum logic [FetchStateBus-1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_t;

  // One prefetch entry: the fetch address travels with its instruction.
  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// ROM bus and IF->ID handshake bundle; master is the fetch controller.
interface if_fetch_ctrl_if;
  import if_fetch_ctrl_pkg::*;

  logic                   rom_ce_o;
  logic [InstAddrBus-1:0] rom_addr_o;
  logic [InstBus-1:0]     rom_inst_i;
  logic                   if_valid_o;
  logic [InstBus-1:0]     if_inst_o;
  logic [InstAddrBus-1:0] if_pc_o;
  logic                   id_ready_i;

  modport master (
    output rom_ce_o, rom_addr_o, if_valid_o, if_inst_o, if_pc_o,
    input  rom_inst_i, id_ready_i
  );

  modport slave (
    input  rom_ce_o, rom_addr_o, if_valid_o, if_inst_o, if_pc_o,
    output rom_inst_i, id_ready_i
  );

endinterface

// File: rtl/if_fetch_ctrl_fifo.sv
// Prefetch FIFO: DEPTH x {pc, inst}, combinational head, synchronous clear.
module fetch_fifo
  import if_fetch_ctrl_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic         valid,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Pointer and occupancy bookkeeping; clear overrides push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage write; contents need no reset since the head is gated by valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wr_data;
  end

  assign valid   = (count != '0);
  assign rd_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives inst_rom, buffers
// fetched words in a small FIFO toward ID. Supports start/halt/flush.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter  logic [31:0] RESET_PC = 32'h0000_0000,
  parameter  logic [31:0] PC_INC   = 32'd16,
  parameter  int unsigned DEPTH    = 2,
  localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   halt_i,
  input  logic                   flush_i,
  input  logic [InstAddrBus-1:0] new_pc_i,
  if_fetch_ctrl_if.master        bus,
  output logic [CW-1:0]          fifo_cnt_o
);

  fetch_state_t           state;
  fetch_state_t           state_nxt;
  logic [InstAddrBus-1:0] pc;
  logic                   pop;
  logic                   push;
  logic                   full;
  fetch_entry_t           head;

  assign full = (fifo_cnt_o == CW'(DEPTH));
  assign pop  = bus.if_valid_o & bus.id_ready_i;
  // A full FIFO still accepts a fetch when the head leaves the same cycle.
  assign push = (state == FETCH_RUN) & ~flush_i & (~full | pop);

  assign bus.rom_ce_o   = push ? ChipEnable : ChipDisable;
  assign bus.rom_addr_o = pc;
  assign bus.if_inst_o  = head.inst;
  assign bus.if_pc_o    = head.pc;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; halt beats start while running, flush never moves state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH_IDLE: if (start_i) state_nxt = FETCH_RUN;
      FETCH_RUN:  if (halt_i)  state_nxt = FETCH_HALT;
      FETCH_HALT: if (start_i) state_nxt = FETCH_RUN;
      default:                 state_nxt = FETCH_IDLE;
    endcase
  end

  // PC: redirect on flush, advance on every issued ROM read, else hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         pc <= RESET_PC;
    else if (flush_i) pc <= new_pc_i;
    else if (push)    pc <= pc + PC_INC;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .clear   (flush_i),
    .wr_data ('{pc: pc, inst: bus.rom_inst_i}),
    .rd_data (head),
    .valid   (bus.if_valid_o),
    .count   (fifo_cnt_o)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: ROM model, reference model with expected-entry
// queue, directed scenarios followed by random start/halt/flush/ready traffic.
module tb_if_fetch_ctrl;

  localparam int unsigned DEPTH    = 2;
  localparam int unsigned CW       = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          halt_i;
  logic          flush_i;
  logic [31:0]   new_pc_i;
  logic [CW-1:0] fifo_cnt_o;

  if_fetch_ctrl_if bus();

  always #5 clk = ~clk;

  // ROM model: zero while disabled, otherwise a tag plus the address.
  assign bus.rom_inst_i = bus.rom_ce_o ? {32'hA5A5_0000, bus.rom_addr_o} : 64'd0;

  if_fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .PC_INC   (32'd16),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .halt_i     (halt_i),
    .flush_i    (flush_i),
    .new_pc_i   (new_pc_i),
    .bus        (bus),
    .fifo_cnt_o (fifo_cnt_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: 0 idle, 1 run, 2 halt; queue holds expected {pc, inst}.
  int          m_state;
  logic [31:0] m_pc;
  logic [95:0] m_q[$];

  task automatic m_reset();
    m_state = 0;
    m_pc    = RESET_PC;
    m_q.delete();
  endtask

  task automatic drive_idle();
    start_i = 1'b0; halt_i = 1'b0; flush_i = 1'b0;
    new_pc_i = 32'd0; bus.id_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    #1;
    chk("rst_ce",    96'(bus.rom_ce_o),   96'd0);
    chk("rst_addr",  96'(bus.rom_addr_o), 96'(RESET_PC));
    chk("rst_valid", 96'(bus.if_valid_o), 96'd0);
    chk("rst_head",  {bus.if_pc_o, bus.if_inst_o}, 96'd0);
    chk("rst_cnt",   96'(fifo_cnt_o),     96'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One cycle: drive at the falling edge, check before the rising edge,
  // then advance the model through that rising edge.
  task automatic step(input logic st, input logic hl, input logic fl,
                      input logic [31:0] npc, input logic rdy);
    logic m_pop;
    logic m_ce;
    @(negedge clk);
    start_i = st; halt_i = hl; flush_i = fl; new_pc_i = npc; bus.id_ready_i = rdy;
    #1;
    m_pop = (m_q.size() != 0) && rdy;
    m_ce  = (m_state == 1) && !fl && ((m_q.size() < DEPTH) || m_pop);
    chk("rom_ce",   96'(bus.rom_ce_o),   96'(m_ce));
    chk("rom_addr", 96'(bus.rom_addr_o), 96'(m_pc));
    chk("fifo_cnt", 96'(fifo_cnt_o),     96'(m_q.size()));
    chk("if_valid", 96'(bus.if_valid_o), 96'(m_q.size() != 0));
    if (m_q.size() != 0) chk("head", {bus.if_pc_o, bus.if_inst_o}, m_q[0]);
    if (m_pop) void'(m_q.pop_front());
    if (fl) begin
      m_q.delete();
      m_pc = npc;
    end else if (m_ce) begin
      m_q.push_back({m_pc, 32'hA5A5_0000, m_pc});
      m_pc = m_pc + 32'd16;
    end
    case (m_state)
      0: if (st) m_state = 1;
      1: if (hl) m_state = 2;
      2: if (st) m_state = 1;
      default: m_state = 0;
    endcase
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    m_reset();

    // Flush while idle only moves the PC.
    do_reset();
    step(0, 0, 1, 32'h40, 0);
    step(0, 0, 0, 32'h0, 0);
    chk("t0_idle_pc", 96'(bus.rom_addr_o), 96'h40);

    // Test 1: start with ID always ready.
    do_reset();
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t1_valid_lag", 96'(bus.if_valid_o), 96'd0);
    step(0, 0, 0, 0, 1);
    chk("t1_head0", {bus.if_pc_o, bus.if_inst_o}, {32'h0, 64'hA5A5_0000_0000_0000});
    step(0, 0, 0, 0, 1);
    chk("t1_head1", {bus.if_pc_o, bus.if_inst_o}, {32'h10, 64'hA5A5_0000_0000_0010});
    step(0, 0, 0, 0, 1);
    chk("t1_head2", {bus.if_pc_o, bus.if_inst_o}, {32'h20, 64'hA5A5_0000_0000_0020});

    // Test 2: backpressure fills the FIFO, then push and pop together.
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    chk("t2_full_cnt",  96'(fifo_cnt_o),     96'd2);
    chk("t2_full_ce",   96'(bus.rom_ce_o),   96'd0);
    chk("t2_full_addr", 96'(bus.rom_addr_o), 96'h20);
    step(0, 0, 0, 0, 1);
    chk("t2_pp_ce", 96'(bus.rom_ce_o), 96'd1);
    step(0, 0, 0, 0, 0);
    chk("t2_pp_cnt", 96'(fifo_cnt_o), 96'd2);

    // Test 3: flush on a full FIFO while ID pops.
    step(0, 0, 1, 32'h100, 1);
    chk("t3_pop_ack", 96'(bus.if_valid_o), 96'd1);
    chk("t3_no_push", 96'(bus.rom_ce_o),   96'd0);
    step(0, 0, 0, 0, 1);
    chk("t3_cnt0", 96'(fifo_cnt_o), 96'd0);
    step(0, 0, 0, 0, 1);
    chk("t3_head_pc", 96'(bus.if_pc_o), 96'h100);

    // Test 4: halt with two entries, drain, resume at sequential PC.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("t4_drained", 96'(bus.if_valid_o), 96'd0);
    chk("t4_halt_ce", 96'(bus.rom_ce_o),   96'd0);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

    // Test 5: redirect near the top of the address space and wrap.
    step(0, 0, 1, 32'hFFFF_FFF0, 1);
    step(0, 0, 0, 0, 1);
    chk("t5_addr_top", 96'(bus.rom_addr_o), 96'hFFFF_FFF0);
    step(0, 0, 0, 0, 1);
    chk("t5_addr_wrap", 96'(bus.rom_addr_o), 96'h0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0);

    // Test 6: asynchronous reset in the middle of a high clock phase.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_ce",    96'(bus.rom_ce_o),   96'd0);
    chk("t6_valid", 96'(bus.if_valid_o), 96'd0);
    chk("t6_addr",  96'(bus.rom_addr_o), 96'(RESET_PC));
    chk("t6_cnt",   96'(fifo_cnt_o),     96'd0);
    m_reset();
    drive_idle();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic against the model.
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 120; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0), {$urandom_range(0, 32'hFFFF), 4'h0} & 32'hFFFF_FFF0,
           ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
